// File: rtl/axi_sram_slave_if.sv
// AXI single-beat bus between the SRAM bridge (master) and axi_sram_slave (slave).
// Five independent valid/ready channels: AR, R, AW, W, B.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );

    modport master (
        output arid, araddr, arlen, arsize, arvalid, rready,
        output awid, awaddr, awlen, awsize, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-beat AXI SRAM: R valid RD_LAT cycles after AR (up to OST_DEPTH in flight), B one cycle after AW+W commit.
// arready drops when the read queue is full, aw/wready while buffered; AXI_SRAM_RAND_DELAY_EN adds LFSR ready/latency jitter.
module axi_sram_slave #(
    parameter int    MEM_AW    = 12,
    parameter int    RD_LAT    = 2,
    parameter int    OST_DEPTH = 2,
    parameter string INIT_FILE = ""
) (
    input  logic            aclk,
    input  logic            aresetn,
    axi_sram_slave_if.slave axi
);
    localparam int PW = $clog2(OST_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  dly;
    } rd_ent_t;

    typedef struct packed {
        logic [3:0]        id;
        logic [MEM_AW-1:0] idx;
        logic              err;
    } aw_buf_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_buf_t;

    logic [31:0] mem [2**MEM_AW];

    logic       ar_gate, aw_gate, w_gate;
    logic [3:0] dly_jit;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end
    assign ar_gate = lfsr_q[0];
    assign aw_gate = lfsr_q[3];
    assign w_gate  = lfsr_q[5];
    assign dly_jit = {2'b00, lfsr_q[2:1]};
`else
    assign ar_gate = 1'b1;
    assign aw_gate = 1'b1;
    assign w_gate  = 1'b1;
    assign dly_jit = 4'd0;
`endif

    // Holds all readies low through reset and until the first clock after release.
    logic ready_en_q;

    rd_ent_t        q_q [OST_DEPTH];
    rd_ent_t        q_d [OST_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    rd_ent_t        head, new_ent;
    logic           ar_hs, ar_err, r_vld, r_hs;

    assign ar_err      = axi.arlen != 8'd0;
    assign axi.arready = ready_en_q && (cnt_q < CW'(OST_DEPTH)) && ar_gate;
    assign ar_hs       = axi.arvalid && axi.arready;
    assign head        = q_q[rd_ptr_q];
    assign r_vld       = (cnt_q != '0) && (head.dly == 4'd0);
    assign r_hs        = r_vld && axi.rready;

    // Memory is sampled in the AR cycle, so a same-cycle commit is not yet visible.
    always_comb begin
        new_ent.id   = axi.arid;
        new_ent.data = ar_err ? 32'h0 : mem[axi.araddr[MEM_AW+1:2]];
        new_ent.resp = ar_err ? 2'b10 : 2'b00;
        new_ent.dly  = 4'(RD_LAT - 1) + dly_jit;
    end

    always_comb begin
        q_d      = q_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < OST_DEPTH; i++) begin
            if (q_q[i].dly != 4'd0) q_d[i].dly = q_q[i].dly - 4'd1;
        end
        if (ar_hs) begin
            q_d[wr_ptr_q] = new_ent;
            wr_ptr_d      = wr_ptr_q + PW'(1);
        end
        if (r_hs) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({ar_hs, r_hs})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign axi.rvalid = r_vld;
    assign axi.rlast  = r_vld;
    assign axi.rid    = r_vld ? head.id   : 4'h0;
    assign axi.rdata  = r_vld ? head.data : 32'h0;
    assign axi.rresp  = r_vld ? head.resp : 2'b00;

    logic     aw_full_q, aw_full_d, w_full_q, w_full_d;
    aw_buf_t  aw_q, aw_d;
    w_buf_t   w_q, w_d;
    logic     b_vld_q, b_vld_d;
    logic [3:0] b_id_q, b_id_d;
    logic [1:0] b_resp_q, b_resp_d;
    logic     aw_hs, w_hs, commit, wr_err;

    assign axi.awready = ready_en_q && !aw_full_q && aw_gate;
    assign axi.wready  = ready_en_q && !w_full_q && w_gate;
    assign aw_hs       = axi.awvalid && axi.awready;
    assign w_hs        = axi.wvalid && axi.wready;
    assign commit      = aw_full_q && w_full_q && (!b_vld_q || axi.bready);
    assign wr_err      = aw_q.err || !w_q.last;

    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        aw_d      = aw_q;
        w_d       = w_q;
        b_vld_d   = b_vld_q;
        b_id_d    = b_id_q;
        b_resp_d  = b_resp_q;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            b_vld_d   = 1'b1;
            b_id_d    = aw_q.id;
            b_resp_d  = wr_err ? 2'b10 : 2'b00;
        end else if (axi.bready) begin
            b_vld_d = 1'b0;
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_d.id   = axi.awid;
            aw_d.idx  = axi.awaddr[MEM_AW+1:2];
            aw_d.err  = axi.awlen != 8'd0;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_d.data = axi.wdata;
            w_d.strb = axi.wstrb;
            w_d.last = axi.wlast;
        end
    end

    assign axi.bvalid = b_vld_q;
    assign axi.bid    = b_id_q;
    assign axi.bresp  = b_resp_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < OST_DEPTH; i++) q_q[i] <= '0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_q       <= '0;
            w_q        <= '0;
            b_vld_q    <= 1'b0;
            b_id_q     <= 4'h0;
            b_resp_q   <= 2'b00;
        end else begin
            ready_en_q <= 1'b1;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            q_q        <= q_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            aw_q       <= aw_d;
            w_q        <= w_d;
            b_vld_q    <= b_vld_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
        end
    end

    // Storage has no reset: contents survive aresetn.
    always_ff @(posedge aclk) begin
        if (commit && !wr_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_q.strb[i]) mem[aw_q.idx][8*i +: 8] <= w_q.data[8*i +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{axi.arsize, axi.awsize, axi.wid,
                           axi.araddr[31:MEM_AW+2], axi.araddr[1:0],
                           axi.awaddr[31:MEM_AW+2], axi.awaddr[1:0]};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed plus randomized bench for axi_sram_slave against a word-array memory model.
`timescale 1ns/1ps
module tb_axi_sram_slave;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_sram_slave_if axi();

    axi_sram_slave #(.MEM_AW(12), .RD_LAT(RD_LAT), .OST_DEPTH(2), .INIT_FILE("")) dut (
        .aclk(clk), .aresetn(rst_n), .axi(axi)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [int];
    int pool [8] = '{16, 53, 90, 127, 164, 201, 238, 275};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mk_addr(input int idx);
        return {18'($urandom), 12'(idx), 2'($urandom)};
    endfunction

    // Waits (bounded) until every raised valid sees its ready; handshake then occurs at the next edge.
    task automatic wait_hs(input string tag);
        int n = 0;
        while (!((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready) &&
                 (!axi.arvalid || axi.arready)) && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 50), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [3:0] id, input logic [7:0] len, input logic last, input int lead);
        logic err;
        err = (len != 8'd0) || !last;
        axi.bready = 1'b1;
        axi.awaddr = addr; axi.awid = id; axi.awlen = len;
        axi.wdata = data; axi.wstrb = strb; axi.wlast = last;
        axi.awvalid = (lead <= 0);
        axi.wvalid  = (lead >= 0);
        wait_hs("w_hs1");
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        if (lead != 0) begin
            repeat ((lead > 0 ? lead : -lead) - 1) tick();
            if (lead > 0) axi.awvalid = 1'b1; else axi.wvalid = 1'b1;
            wait_hs("w_hs2");
            tick();
            axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        end
        chk("b_early", 32'(axi.bvalid), 32'd0);
        tick();
        chk("b_vld", 32'(axi.bvalid), 32'd1);
        chk("b_id", 32'(axi.bid), 32'(id));
        chk("b_resp", 32'(axi.bresp), err ? 32'd2 : 32'd0);
        if (!err) mdl[widx(addr)] = merge(mdl.exists(widx(addr)) ? mdl[widx(addr)] : 32'h0, data, strb);
        tick();
        chk("b_pop", 32'(axi.bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        int lat;
        logic [31:0] exp;
        exp = (len != 8'd0) ? 32'h0 : mdl[widx(addr)];
        axi.rready = 1'b1;
        axi.araddr = addr; axi.arid = id; axi.arlen = len; axi.arvalid = 1'b1;
        wait_hs("r_hs");
        tick();
        axi.arvalid = 1'b0;
        lat = 1;
        while (!axi.rvalid && lat < 20) begin
            tick();
            lat++;
        end
        chk("r_lat", 32'(lat), 32'(RD_LAT));
        chk("r_data", axi.rdata, exp);
        chk("r_id", 32'(axi.rid), 32'(id));
        chk("r_resp", 32'(axi.rresp), (len != 8'd0) ? 32'd2 : 32'd0);
        chk("r_last", 32'(axi.rlast), 32'd1);
        tick();
        chk("r_pop", 32'(axi.rvalid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e0, e1, e2;
        int lead;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd2; axi.arvalid = 1'b0; axi.rready = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd2; axi.awvalid = 1'b0;
        axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b1; axi.wvalid = 1'b0; axi.bready = 1'b0;

        // Reset state
        #23;
        chk("rst_arready", 32'(axi.arready), 32'd0);
        chk("rst_awready", 32'(axi.awready), 32'd0);
        chk("rst_wready", 32'(axi.wready), 32'd0);
        chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
        chk("rst_rdata", axi.rdata, 32'h0);
        chk("rst_rlast", 32'(axi.rlast), 32'd0);
        chk("rst_bid", 32'(axi.bid), 32'd0);
        #4 rst_n = 1'b1;
        tick();
        chk("rel_arready", 32'(axi.arready), 32'd1);
        chk("rel_awready", 32'(axi.awready), 32'd1);
        chk("rel_wready", 32'(axi.wready), 32'd1);

        // Write then read, then W-before-AW partial write
        do_write(32'h100, 32'h12345678, 4'hF, 4'h9, 8'd0, 1'b1, 0);
        do_read(32'h100, 4'h3, 8'd0);
        do_write(32'h100, 32'hAABBCCDD, 4'b0101, 4'h2, 8'd0, 1'b1, 3);
        do_read(32'h100, 4'h4, 8'd0);

        // Error responses
        do_read(32'h100, 4'h7, 8'd1);
        do_write(32'h100, 32'hDEADBEEF, 4'hF, 4'h5, 8'd2, 1'b1, 0);
        do_write(32'h100, 32'hDEADBEEF, 4'hF, 4'h6, 8'd0, 1'b0, -2);
        do_read(32'h100, 4'h8, 8'd0);

        // Back-pressure on R with a full outstanding queue
        do_write(32'h300, $urandom, 4'hF, 4'h1, 8'd0, 1'b1, 0);
        do_write(32'h304, $urandom, 4'hF, 4'h1, 8'd0, 1'b1, -1);
        do_write(32'h308, $urandom, 4'hF, 4'h1, 8'd0, 1'b1, 1);
        e0 = mdl[widx(32'h300)]; e1 = mdl[widx(32'h304)]; e2 = mdl[widx(32'h308)];
        axi.rready = 1'b0; axi.arlen = 8'd0;
        axi.araddr = 32'h300; axi.arid = 4'h0; axi.arvalid = 1'b1;
        chk("bp_rdy0", 32'(axi.arready), 32'd1);
        tick();
        axi.araddr = 32'h304; axi.arid = 4'h1;
        chk("bp_rdy1", 32'(axi.arready), 32'd1);
        tick();
        axi.araddr = 32'h308; axi.arid = 4'h2;
        chk("bp_full", 32'(axi.arready), 32'd0);
        chk("bp_rvalid0", 32'(axi.rvalid), 32'd1);
        chk("bp_rdata0", axi.rdata, e0);
        repeat (3) tick();
        chk("bp_still_full", 32'(axi.arready), 32'd0);
        chk("bp_hold_data", axi.rdata, e0);
        chk("bp_hold_id", 32'(axi.rid), 32'd0);
        axi.rready = 1'b1;
        chk("bp_pop_cycle", 32'(axi.arready), 32'd0);
        tick();
        chk("bp_slot_free", 32'(axi.arready), 32'd1);
        chk("bp_rid1", 32'(axi.rid), 32'd1);
        chk("bp_rdata1", axi.rdata, e1);
        tick();
        axi.arvalid = 1'b0;
        chk("bp_gap", 32'(axi.rvalid), 32'd0);
        tick();
        chk("bp_rvalid2", 32'(axi.rvalid), 32'd1);
        chk("bp_rid2", 32'(axi.rid), 32'd2);
        chk("bp_rdata2", axi.rdata, e2);
        tick();
        chk("bp_drained", 32'(axi.rvalid), 32'd0);

        // Same-cycle read/commit hazard
        do_write(32'h200, 32'h0, 4'hF, 4'h1, 8'd0, 1'b1, 0);
        axi.bready = 1'b1; axi.rready = 1'b1;
        axi.awaddr = 32'h200; axi.awid = 4'hA; axi.awlen = 8'd0;
        axi.wdata = 32'hFFFF0000; axi.wstrb = 4'hF; axi.wlast = 1'b1;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        wait_hs("hz_whs");
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.araddr = 32'h200; axi.arid = 4'h5; axi.arlen = 8'd0; axi.arvalid = 1'b1;
        chk("hz_ar_commit", 32'(axi.arready), 32'd1);
        tick();
        axi.arid = 4'h6;
        chk("hz_b", 32'(axi.bvalid), 32'd1);
        chk("hz_ar_after", 32'(axi.arready), 32'd1);
        tick();
        axi.arvalid = 1'b0;
        chk("hz_rid_old", 32'(axi.rid), 32'd5);
        chk("hz_old", axi.rdata, 32'h0);
        tick();
        chk("hz_rid_new", 32'(axi.rid), 32'd6);
        chk("hz_new", axi.rdata, 32'hFFFF0000);
        mdl[widx(32'h200)] = 32'hFFFF0000;
        tick();

        // Randomized traffic with address aliasing
        for (int i = 0; i < 8; i++) do_write(mk_addr(pool[i]), $urandom, 4'hF, 4'($urandom), 8'd0, 1'b1, 0);
        for (int i = 0; i < 40; i++) begin
            int k;
            k = int'($urandom_range(7));
            if ($urandom_range(1) == 1) begin
                lead = int'($urandom_range(4)) - 2;
                do_write(mk_addr(pool[k]), $urandom, 4'($urandom), 4'($urandom), 8'd0, 1'b1, lead);
            end else begin
                do_read(mk_addr(pool[k]), 4'($urandom), 8'd0);
            end
        end

        // Reset with R and B pending
        axi.rready = 1'b0; axi.bready = 1'b0;
        axi.awaddr = 32'h300; axi.awid = 4'hC; axi.awlen = 8'd0;
        axi.wdata = 32'h5A5A5A5A; axi.wstrb = 4'hF; axi.wlast = 1'b1;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        wait_hs("rst_whs");
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        tick();
        mdl[widx(32'h300)] = 32'h5A5A5A5A;
        axi.araddr = 32'h304; axi.arid = 4'h4; axi.arlen = 8'd0; axi.arvalid = 1'b1;
        wait_hs("rst_arhs");
        tick();
        axi.arvalid = 1'b0;
        tick();
        chk("pre_rst_rvalid", 32'(axi.rvalid), 32'd1);
        chk("pre_rst_bvalid", 32'(axi.bvalid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("mid_rst_bvalid", 32'(axi.bvalid), 32'd0);
        chk("mid_rst_rdata", axi.rdata, 32'h0);
        chk("mid_rst_arready", 32'(axi.arready), 32'd0);
        chk("mid_rst_wready", 32'(axi.wready), 32'd0);
        axi.rready = 1'b1; axi.bready = 1'b1;
        repeat (2) tick();
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_arready", 32'(axi.arready), 32'd1);
        chk("post_rst_awready", 32'(axi.awready), 32'd1);
        chk("post_rst_wready", 32'(axi.wready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("stale_r", 32'(axi.rvalid), 32'd0);
            chk("stale_b", 32'(axi.bvalid), 32'd0);
            tick();
        end
        do_read(32'h300, 4'hE, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
